// File: rtl/radix2_signed_divider.sv
// Sequential 8-bit signed divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per clock, sign correction and special-case handling in a final step.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// CALC  | eight restoring iterations, quotient bits MSB-first
// FIX   | apply signs / special cases, load outputs, pulse done
module radix2_signed_divider (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic signed [7:0] in1,
  input  logic signed [7:0] in2,
  output logic              busy,
  output logic              done,
  output logic signed [7:0] quotient,
  output logic signed [7:0] remainder,
  output logic              div_by_zero,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t      state_q;
  logic [7:0]  a_q, b_q;
  logic [8:0]  mag_a_q, mag_b_q, rem_q;
  logic [2:0]  cnt_q;
  logic        qsign_q, rsign_q;
  logic        busy_q, done_q, dbz_q, ovf_q;
  logic [7:0]  quo_q, remo_q;

  logic [8:0]  mag1_d, mag2_d, trial_d, diff_d;
  logic        qbit_d;
  logic [7:0]  qfix_d, rfix_d;

  // 9-bit magnitudes so that |-128| = 128 is representable
  assign mag1_d  = in1[7] ? (9'd0 - {in1[7], in1}) : {1'b0, in1};
  assign mag2_d  = in2[7] ? (9'd0 - {in2[7], in2}) : {1'b0, in2};

  // mag_a_q shifts left; its low bits fill with quotient bits as the dividend drains out
  assign trial_d = {rem_q[7:0], mag_a_q[7]};
  assign qbit_d  = (trial_d >= mag_b_q);
  assign diff_d  = trial_d - mag_b_q;

  assign qfix_d  = qsign_q ? (8'd0 - mag_a_q[7:0]) : mag_a_q[7:0];
  assign rfix_d  = rsign_q ? (8'd0 - rem_q[7:0])   : rem_q[7:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      quo_q   <= '0;
      remo_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= in1;
            b_q     <= in2;
            mag_a_q <= mag1_d;
            mag_b_q <= mag2_d;
            rem_q   <= '0;
            qsign_q <= in1[7] ^ in2[7];
            rsign_q <= in1[7];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q   <= qbit_d ? diff_d : trial_d;
          mag_a_q <= {mag_a_q[7:0], qbit_d};
          cnt_q   <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_q <= FIX;
        end
        FIX: begin
          if (b_q == 8'h00) begin
            quo_q  <= 8'hFF;
            remo_q <= a_q;
            dbz_q  <= 1'b1;
            ovf_q  <= 1'b0;
          end else if (a_q == 8'h80 && b_q == 8'hFF) begin
            quo_q  <= 8'h80;
            remo_q <= 8'h00;
            dbz_q  <= 1'b0;
            ovf_q  <= 1'b1;
          end else begin
            quo_q  <= qfix_d;
            remo_q <= rfix_d;
            dbz_q  <= 1'b0;
            ovf_q  <= 1'b0;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: doc/radix2_signed_divider.md
RADIX2_SIGNED_DIVIDER -- requirements
Module: radix2_signed_divider

Interface
REQ-001 The block SHALL provide these ports:
- clk, input, 1 bit: single clock; all state updates on the rising edge.
- rst, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
- start, input, 1 bit: request to begin a division; sampled only in IDLE.
- in1, input, 8 bits, signed: dividend.
- in2, input, 8 bits, signed: divisor.
- busy, output, 1 bit: high while a division is in progress.
- done, output, 1 bit: one-cycle pulse marking a valid result.
- quotient, output, 8 bits, signed: registered quotient.
- remainder, output, 8 bits, signed: registered remainder.
- div_by_zero, output, 1 bit: registered flag for a zero divisor.
- overflow, output, 1 bit: registered flag for -128 / -1.

REQ-002 The block SHALL have no parameters; the width is fixed at 8 bits.

Function
REQ-003 The block SHALL implement the states IDLE, CALC, FIX and, on reset, SHALL enter IDLE.
REQ-004 In IDLE with start=1 at rising edge k, the block SHALL perform all of the following:
- capture in1 and in2;
- store the magnitudes of both operands in internal registers 9 bits wide or wider, so that |-128| is representable;
- record the quotient sign (sign(in1) XOR sign(in2)) and the remainder sign (sign(in1));
- clear the iteration counter;
- enter CALC.
REQ-005 In CALC, each rising edge SHALL perform one restoring shift-subtract iteration on the magnitudes, producing one quotient bit MSB-first; after exactly 8 iterations (edges k+1..k+8) the state SHALL be FIX.
REQ-006 At edge k+9 (FIX), the block SHALL apply sign correction, load quotient, remainder, div_by_zero and overflow, pulse done=1 and return to IDLE.
- Latency: done is high for the single cycle following edge k+9.
REQ-007 busy SHALL be 1 in CALC and FIX and 0 in IDLE.
REQ-008 Results SHALL be truncated toward zero.
- The remainder sign SHALL equal the dividend sign, or the remainder is 0.
- in1 = quotient*in2 + remainder SHALL hold whenever div_by_zero=0 and overflow=0.
REQ-009 When in2 = 0, the block SHALL output quotient = -1 (8'hFF), remainder = in1 and div_by_zero = 1, with the same latency as a normal division.
REQ-010 When in1 = -128 and in2 = -1, the block SHALL output quotient = -128, remainder = 0 and overflow = 1, with the same latency.
REQ-011 div_by_zero and overflow SHALL be 0 for all other operand pairs, and SHALL be updated only in FIX.
REQ-012 start while busy=1 SHALL be ignored; it SHALL not corrupt the division in progress or its operands.
REQ-013 Changes on in1 and in2 after the start edge SHALL not affect the result.
REQ-014 quotient, remainder and the flags SHALL hold their values from the last FIX until the next FIX or reset.
REQ-015 start=1 in the cycle in which done=1 SHALL be accepted at the next edge, allowing back-to-back divisions every 10 cycles.

Reset
REQ-016 rst=0 SHALL immediately, without waiting for clk, set all of the following:
- state to IDLE;
- busy = 0 and done = 0;
- quotient = 0 and remainder = 0;
- div_by_zero = 0 and overflow = 0;
- all internal registers to 0.
REQ-017 Reset asserted mid-division (CALC or FIX) SHALL abort it; no done pulse SHALL follow its release.
REQ-018 After rst returns to 1, the first rising edge with start=1 SHALL begin a new division normally.

Verification
REQ-019 in1=-80, in2=10, start pulse -> done exactly 10 cycles later; quotient=-8, remainder=0, flags 0.
REQ-020 Sign rules, each checked separately:
- in1=100, in2=7 -> quotient=14, remainder=2;
- in1=-7, in2=2 -> quotient=-3, remainder=-1;
- in1=7, in2=-2 -> quotient=-3, remainder=1.
REQ-021 in1=25, in2=0 -> quotient=-1, remainder=25, div_by_zero=1, overflow=0, done at cycle 10.
REQ-022 in1=-128, in2=-1 -> quotient=-128, remainder=0, overflow=1; then in1=-128, in2=1 -> quotient=-128, remainder=0, overflow=0.
REQ-023 Handshake robustness:
- start 100/7; at cycle 3 drive start=1 with in1=50, in2=5 -> exactly one done, result 14 r 2;
- re-run 100/7, then drive start in the done cycle with 50/5 -> second done 10 cycles later, result 10 r 0.
REQ-024 start -96/3; assert rst=0 asynchronously at cycle 5 -> outputs 0 immediately; release rst -> no done appears; a new 9/4 division yields quotient=2, remainder=1.
